// File: rtl/timer_irq_ctrl.sv
// APB3 interrupt aggregator: level/edge capture into PENDING, masking by ENABLE,
// and a registered lowest-index-wins request plus source ID for the core.
module timer_irq_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 5
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic               PSEL,
  input  logic               PENABLE,
  input  logic               PWRITE,
  input  logic [2:0]         PADDR,
  input  logic [31:0]        PWDATA,
  output logic [31:0]        PRDATA,
  input  logic [NUM_IRQ-1:0] IRQ_SRC,
  output logic               IRQ,
  output logic [ID_W-1:0]    IRQ_ID
);

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_PENDING = 3'd1;
  localparam logic [2:0] ADDR_ENABLE  = 3'd2;
  localparam logic [2:0] ADDR_MODE    = 3'd3;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd4;
  localparam logic [2:0] ADDR_SWSET   = 3'd5;

  logic [NUM_IRQ-1:0] pending_reg, pending_next;
  logic [NUM_IRQ-1:0] enable_reg;
  logic [NUM_IRQ-1:0] mode_reg;
  logic [NUM_IRQ-1:0] src_q_reg;
  logic               irq_reg;
  logic [ID_W-1:0]    irq_id_reg, irq_id_next;

  logic               wr_en;
  logic [NUM_IRQ-1:0] wr_bits;
  logic [NUM_IRQ-1:0] w1c;
  logic [NUM_IRQ-1:0] swset;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] set_vec;
  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] rd_word;
  logic               unused_pwdata;

  assign wr_en         = PSEL & PENABLE & PWRITE;
  assign wr_bits       = PWDATA[NUM_IRQ-1:0];
  assign unused_pwdata = ^PWDATA[31:NUM_IRQ];

  assign w1c    = (wr_en && PADDR == ADDR_PENDING) ? wr_bits : '0;
  assign swset  = (wr_en && PADDR == ADDR_SWSET)   ? wr_bits : '0;
  assign rise   = IRQ_SRC & ~src_q_reg;
  assign active = pending_reg & enable_reg;

  // Set terms are ORed after the clear term so a same-cycle set beats a W1C.
  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_pend
    assign set_vec[gi]      = mode_reg[gi] ? rise[gi] : IRQ_SRC[gi];
    assign pending_next[gi] = set_vec[gi] | swset[gi] | (pending_reg[gi] & ~w1c[gi]);
  end

  always_comb begin
    irq_id_next = '1;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) irq_id_next = ID_W'(i);
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      pending_reg <= '0;
      enable_reg  <= '0;
      mode_reg    <= '0;
      src_q_reg   <= '0;
      irq_reg     <= 1'b0;
      irq_id_reg  <= '1;
    end else begin
      pending_reg <= pending_next;
      src_q_reg   <= IRQ_SRC;
      irq_reg     <= |active;
      irq_id_reg  <= irq_id_next;
      if (wr_en && PADDR == ADDR_ENABLE) enable_reg <= wr_bits;
      if (wr_en && PADDR == ADDR_MODE)   mode_reg   <= wr_bits;
    end
  end

  always_comb begin
    rd_word = '0;
    case (PADDR)
      ADDR_STATUS:  rd_word = IRQ_SRC;
      ADDR_PENDING: rd_word = pending_reg;
      ADDR_ENABLE:  rd_word = enable_reg;
      ADDR_MODE:    rd_word = mode_reg;
      ADDR_ACTIVE:  rd_word = active;
      default:      rd_word = '0;
    endcase
    PRDATA = '0;
    if (PSEL && !PWRITE) PRDATA = {{(32 - NUM_IRQ){1'b0}}, rd_word};
  end

  assign IRQ    = irq_reg;
  assign IRQ_ID = irq_id_reg;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Scoreboard bench for timer_irq_ctrl: expected values are queued as stimulus
// is driven and popped when the corresponding DUT output is sampled.
module tb_timer_irq_ctrl;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        PSEL, PENABLE, PWRITE;
  logic [2:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic [7:0]  IRQ_SRC;
  logic        IRQ;
  logic [4:0]  IRQ_ID;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];

  timer_irq_ctrl #(.NUM_IRQ(8), .ID_W(5)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .IRQ_SRC (IRQ_SRC),
    .IRQ     (IRQ),
    .IRQ_ID  (IRQ_ID)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // Read a register in the current cycle (caller positions us after a negedge).
  task automatic rd_chk(input string tag, input logic [2:0] addr, input logic [31:0] exp);
    sb_item_t it;
    sb_q.push_back('{tag, exp});
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
    #1;
    it = sb_q.pop_front();
    check(it.tag, PRDATA, it.exp);
    PSEL = 1'b0;
  endtask

  task automatic irq_chk(input string tag, input logic exp_irq, input logic [4:0] exp_id);
    sb_item_t it;
    sb_q.push_back('{tag, 32'({exp_irq, exp_id})});
    #1;
    it = sb_q.pop_front();
    check(it.tag, 32'({IRQ, IRQ_ID}), it.exp);
  endtask

  // Returns one negedge after the commit edge: the register reflects the write.
  task automatic apb_wr(input logic [2:0] addr, input logic [31:0] data);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 3'd0; PWDATA = 32'h0; IRQ_SRC = 8'h00;
    idle(3);
    PRESET = 1'b0;

    // Reset state: every word reads 0, no request, ID all ones.
    irq_chk("rst_irq", 1'b0, 5'h1F);
    for (int a = 0; a < 8; a++) begin
      rd_chk($sformatf("rst_rd%0d", a), 3'(a), 32'h0);
    end

    // Edge capture on bit 0 with exact latency.
    apb_wr(3'd3, 32'h01);
    apb_wr(3'd2, 32'h01);
    @(negedge PCLK); IRQ_SRC = 8'h01;          // cycle N
    @(negedge PCLK); IRQ_SRC = 8'h00;          // cycle N+1
    rd_chk("edge_pend_n1", 3'd1, 32'h01);
    irq_chk("edge_irq_n1", 1'b0, 5'h1F);
    @(negedge PCLK);                            // cycle N+2
    irq_chk("edge_irq_n2", 1'b1, 5'd0);
    apb_wr(3'd1, 32'h01);
    rd_chk("edge_w1c_pend", 3'd1, 32'h00);
    irq_chk("edge_w1c_n1", 1'b1, 5'd0);
    @(negedge PCLK);
    irq_chk("edge_w1c_n2", 1'b0, 5'h1F);

    // Level hold on bit 2: W1C is ineffective while the source is high.
    apb_wr(3'd3, 32'h00);
    apb_wr(3'd2, 32'h04);
    @(negedge PCLK); IRQ_SRC = 8'h04;
    idle(3);
    irq_chk("lvl_irq", 1'b1, 5'd2);
    apb_wr(3'd1, 32'h04);
    rd_chk("lvl_w1c_held", 3'd1, 32'h04);
    idle(2);
    irq_chk("lvl_irq_held", 1'b1, 5'd2);
    @(negedge PCLK); IRQ_SRC = 8'h00;
    idle(1);
    rd_chk("lvl_dropped_pend", 3'd1, 32'h04);
    apb_wr(3'd1, 32'h04);
    rd_chk("lvl_w1c_pend", 3'd1, 32'h00);
    idle(1);
    irq_chk("lvl_w1c_irq", 1'b0, 5'h1F);

    // Priority and mask; upper write bits are ignored.
    apb_wr(3'd2, 32'hFFFF_FF0A);
    rd_chk("prio_enable", 3'd2, 32'h0A);
    apb_wr(3'd5, 32'h0E);
    rd_chk("prio_pend", 3'd1, 32'h0E);
    rd_chk("prio_active", 3'd4, 32'h0A);
    rd_chk("prio_swset_rd", 3'd5, 32'h00);
    @(negedge PCLK);
    irq_chk("prio_id1", 1'b1, 5'd1);
    apb_wr(3'd1, 32'h02);
    @(negedge PCLK);
    irq_chk("prio_id3", 1'b1, 5'd3);
    apb_wr(3'd1, 32'h08);
    @(negedge PCLK);
    irq_chk("prio_none", 1'b0, 5'h1F);
    rd_chk("prio_pend_left", 3'd1, 32'h04);

    // STATUS reflects raw inputs; masked sources pend but never request.
    @(negedge PCLK); IRQ_SRC = 8'h50;
    #1;
    rd_chk("status_raw", 3'd0, 32'h50);
    @(negedge PCLK); IRQ_SRC = 8'h00;
    rd_chk("masked_pend", 3'd1, 32'h54);
    idle(1);
    irq_chk("masked_irq", 1'b0, 5'h1F);
    apb_wr(3'd1, 32'hFF);

    // Set/clear collision in edge mode: the rise wins over the W1C.
    apb_wr(3'd3, 32'h01);
    apb_wr(3'd5, 32'h01);
    rd_chk("coll_pre", 3'd1, 32'h01);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = 3'd1; PWDATA = 32'h01;
    @(negedge PCLK);
    PENABLE = 1'b1; IRQ_SRC = 8'h01;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    rd_chk("coll_pend", 3'd1, 32'h01);
    apb_wr(3'd1, 32'h01);
    rd_chk("edge_held_no_refill", 3'd1, 32'h00);
    IRQ_SRC = 8'h00;

    // Reset during an ENABLE write enable phase.
    apb_wr(3'd2, 32'hFF);
    apb_wr(3'd5, 32'h01);
    @(negedge PCLK);
    irq_chk("rstmid_pre", 1'b1, 5'd0);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = 3'd2; PWDATA = 32'h00;
    @(negedge PCLK);
    PENABLE = 1'b1; PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    irq_chk("rstmid_irq", 1'b0, 5'h1F);
    rd_chk("rstmid_enable", 3'd2, 32'h00);
    rd_chk("rstmid_pend", 3'd1, 32'h00);
    rd_chk("rstmid_mode", 3'd3, 32'h00);

    check("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
